// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and small helpers used by the timing generator.
// Defaults describe 640x480@60 with a 25.175 MHz-class pixel clock.
package vga_timing_pkg;

   localparam int unsigned VGA_H_ACTIVE = 640;
   localparam int unsigned VGA_H_FP     = 16;
   localparam int unsigned VGA_H_SYNC   = 96;
   localparam int unsigned VGA_H_BP     = 48;
   localparam int unsigned VGA_V_ACTIVE = 480;
   localparam int unsigned VGA_V_FP     = 10;
   localparam int unsigned VGA_V_SYNC   = 2;
   localparam int unsigned VGA_V_BP     = 33;

   localparam logic SYNC_ACTIVE_LOW  = 1'b0;
   localparam logic SYNC_ACTIVE_HIGH = 1'b1;

   // Total period of one axis: visible + front porch + sync + back porch.
   function automatic int unsigned timing_total(input int unsigned active,
                                                input int unsigned fp,
                                                input int unsigned sync,
                                                input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

   // Bits needed to count 0..n-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
   endfunction

   // Half-open window test lo <= v < hi.
   function automatic logic in_window(input int unsigned v,
                                      input int unsigned lo,
                                      input int unsigned hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// Pixel-rate divider: flags that the next enabled clock is a pixel clock.
// The flag is registered so the counters can advance on that same edge.
module pix_tick_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned CLK_DIV = 1
)(
   input  logic clk,
   input  logic reset_n,
   input  logic run,
   output logic pix_tick
);

   localparam int unsigned      DIV_W    = cnt_width(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] w_div_nxt;
   logic             r_wrap_pend;

   always_comb begin
      w_div_nxt = r_div;
      if (run) begin
         w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
      end
   end

   // Pending flag tracks "divider sits on its last count"; with CLK_DIV=1 it is always set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_div       <= '0;
         r_wrap_pend <= (DIV_LAST == '0);
      end else begin
         r_div       <= w_div_nxt;
         r_wrap_pend <= (w_div_nxt == DIV_LAST);
      end
   end

   assign pix_tick = r_wrap_pend;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: column/row counters with registered sync, blanking and
// frame/line pulses decoded from next-state counts so everything is zero-skew.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
   parameter int unsigned H_FP     = VGA_H_FP,
   parameter int unsigned H_SYNC   = VGA_H_SYNC,
   parameter int unsigned H_BP     = VGA_H_BP,
   parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
   parameter int unsigned V_FP     = VGA_V_FP,
   parameter int unsigned V_SYNC   = VGA_V_SYNC,
   parameter int unsigned V_BP     = VGA_V_BP,
   parameter logic        HS_POL   = SYNC_ACTIVE_LOW,
   parameter logic        VS_POL   = SYNC_ACTIVE_LOW,
   parameter int unsigned CLK_DIV  = 1,
   parameter int unsigned FC_W     = 8,
   localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
   localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
   localparam int unsigned COL_W   = cnt_width(H_TOTAL),
   localparam int unsigned ROW_W   = cnt_width(V_TOTAL)
)(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             run,
   output logic [COL_W-1:0] column,
   output logic [ROW_W-1:0] row,
   output logic             h_sync,
   output logic             v_sync,
   output logic             active,
   output logic             pix_tick,
   output logic             line_start,
   output logic             frame_start,
   output logic [FC_W-1:0]  frame_count
);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_TOTAL - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_TOTAL - 1);
   localparam int unsigned      HS_START = H_ACTIVE + H_FP;
   localparam int unsigned      HS_END   = HS_START + H_SYNC;
   localparam int unsigned      VS_START = V_ACTIVE + V_FP;
   localparam int unsigned      VS_END   = VS_START + V_SYNC;

   logic             w_div_tick;
   logic             w_tick;
   logic             w_line_wrap;
   logic             w_frame_wrap;
   logic [COL_W-1:0] w_col_nxt;
   logic [ROW_W-1:0] w_row_nxt;
   logic             w_hs_nxt;
   logic             w_vs_nxt;
   logic             w_active_nxt;

   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic             r_hs;
   logic             r_vs;
   logic             r_active;
   logic             r_pix_tick;
   logic             r_line_start;
   logic             r_frame_start;
   logic [FC_W-1:0]  r_frame_count;

   pix_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_pix_tick_gen (
      .clk      (clk),
      .reset_n  (reset_n),
      .run      (run),
      .pix_tick (w_div_tick)
   );

   // Next counter values and their decodes; run=0 kills the tick so all state holds.
   always_comb begin
      w_tick       = run & w_div_tick;
      w_line_wrap  = w_tick && (r_col == COL_LAST);
      w_frame_wrap = w_line_wrap && (r_row == ROW_LAST);
      w_col_nxt    = r_col;
      w_row_nxt    = r_row;
      if (w_tick) begin
         w_col_nxt = w_line_wrap ? '0 : r_col + COL_W'(1);
      end
      if (w_line_wrap) begin
         w_row_nxt = w_frame_wrap ? '0 : r_row + ROW_W'(1);
      end
      w_hs_nxt     = in_window(32'(w_col_nxt), HS_START, HS_END) ? HS_POL : ~HS_POL;
      w_vs_nxt     = in_window(32'(w_row_nxt), VS_START, VS_END) ? VS_POL : ~VS_POL;
      w_active_nxt = (32'(w_col_nxt) < H_ACTIVE) && (32'(w_row_nxt) < V_ACTIVE);
   end

   // Reset parks the raster on its last pixel so the first tick lands on (0,0).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_col         <= COL_LAST;
         r_row         <= ROW_LAST;
         r_hs          <= ~HS_POL;
         r_vs          <= ~VS_POL;
         r_active      <= 1'b0;
         r_pix_tick    <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_count <= '0;
      end else begin
         r_col         <= w_col_nxt;
         r_row         <= w_row_nxt;
         r_hs          <= w_hs_nxt;
         r_vs          <= w_vs_nxt;
         r_active      <= w_active_nxt;
         r_pix_tick    <= w_tick;
         r_line_start  <= w_line_wrap;
         r_frame_start <= w_frame_wrap;
         r_frame_count <= r_frame_count + FC_W'(w_frame_wrap);
      end
   end

   assign column      = r_col;
   assign row         = r_row;
   assign h_sync      = r_hs;
   assign v_sync      = r_vs;
   assign active      = r_active;
   assign pix_tick    = r_pix_tick;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;
   assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing instance against a scoreboard model and
// vector table, plus reduced-raster instances for divider, polarity and frame counting.
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- default 640x480 instance ----------------
   logic       rst_def = 1'b0;
   logic       run_def = 1'b1;
   logic [9:0] d_col, d_row;
   logic       d_hs, d_vs, d_act, d_pt, d_ls, d_fs;
   logic [7:0] d_fc;

   vga_timing_gen u_def (
      .clk(clk), .reset_n(rst_def), .run(run_def),
      .column(d_col), .row(d_row), .h_sync(d_hs), .v_sync(d_vs), .active(d_act),
      .pix_tick(d_pt), .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
   );

   // ---------------- reduced rasters: 16x10 total, 8x6 visible ----------------
   logic       rst_s   = 1'b0;
   logic       run_one = 1'b1;
   logic [3:0] f_col, f_row, d2_col, d2_row, p_col, p_row;
   logic       f_hs, f_vs, f_act, f_pt, f_ls, f_fs;
   logic       d2_hs, d2_vs, d2_act, d2_pt, d2_ls, d2_fs;
   logic       p_hs, p_vs, p_act, p_pt, p_ls, p_fs;
   logic [1:0] f_fc;
   logic [7:0] d2_fc, p_fc;

   vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .FC_W(2)) u_fc (
      .clk(clk), .reset_n(rst_s), .run(run_one),
      .column(f_col), .row(f_row), .h_sync(f_hs), .v_sync(f_vs), .active(f_act),
      .pix_tick(f_pt), .line_start(f_ls), .frame_start(f_fs), .frame_count(f_fc)
   );

   vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(2)) u_d2 (
      .clk(clk), .reset_n(rst_s), .run(run_one),
      .column(d2_col), .row(d2_row), .h_sync(d2_hs), .v_sync(d2_vs), .active(d2_act),
      .pix_tick(d2_pt), .line_start(d2_ls), .frame_start(d2_fs), .frame_count(d2_fc)
   );

   vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
                    .HS_POL(SYNC_ACTIVE_HIGH), .VS_POL(SYNC_ACTIVE_HIGH)) u_pol (
      .clk(clk), .reset_n(rst_s), .run(run_one),
      .column(p_col), .row(p_row), .h_sync(p_hs), .v_sync(p_vs), .active(p_act),
      .pix_tick(p_pt), .line_start(p_ls), .frame_start(p_fs), .frame_count(p_fc)
   );

   // ---------------- scoreboard for the default instance ----------------
   typedef struct packed {
      logic [9:0] col;
      logic [9:0] row;
      logic       hs, vs, act, pt, ls, fs;
      logic [7:0] fc;
   } obs_t;

   obs_t q_exp[$];
   int   m_col = 799, m_row = 524, m_fc = 0;
   bit   m_pt = 0, m_ls = 0, m_fs = 0;

   always @(negedge rst_def) begin
      m_col = 799; m_row = 524; m_fc = 0; m_pt = 0; m_ls = 0; m_fs = 0;
   end

   always @(posedge clk) begin : sb
      obs_t e, a;
      if (!rst_def) begin
         m_col = 799; m_row = 524; m_fc = 0; m_pt = 0; m_ls = 0; m_fs = 0;
      end else if (run_def) begin
         m_pt = 1;
         m_ls = (m_col == 799);
         m_fs = m_ls && (m_row == 524);
         m_col = m_ls ? 0 : m_col + 1;
         if (m_ls) m_row = (m_row == 524) ? 0 : m_row + 1;
         if (m_fs) m_fc = (m_fc + 1) % 256;
      end else begin
         m_pt = 0; m_ls = 0; m_fs = 0;
      end
      e.col = 10'(m_col);
      e.row = 10'(m_row);
      e.hs  = !(m_col >= 656 && m_col < 752);
      e.vs  = !(m_row >= 490 && m_row < 492);
      e.act = (m_col < 640) && (m_row < 480);
      e.pt  = m_pt;
      e.ls  = m_ls;
      e.fs  = m_fs;
      e.fc  = 8'(m_fc);
      q_exp.push_back(e);
      #1;
      a = {d_col, d_row, d_hs, d_vs, d_act, d_pt, d_ls, d_fs, d_fc};
      e = q_exp.pop_front();
      chk("sb_default", 64'(a), 64'(e));
   end

   // ---------------- monitors for the reduced-raster instances ----------------
   bit s_en = 0;
   int s_cyc = 0;
   int fc_frames = 0, f_last_fs = 0, f_act_cnt = 0, f_vs_lo_cnt = 0;
   int d2_frames = 0, d2_last = 0;
   int p_lines = 0, p_hs_cnt = 0, p_frames = 0, p_vs_cnt = 0;
   int fc_seq [5] = '{1, 2, 3, 0, 1};

   always @(posedge clk) begin
      #1;
      if (s_en) begin
         s_cyc++;
         if (fc_frames < 5) begin
            if (f_fs) begin
               chk("fc_sequence", 64'(f_fc), 64'(fc_seq[fc_frames]));
               chk("fs_has_ls", 64'(f_ls), 64'd1);
               if (fc_frames > 0) begin
                  chk("frame_period", 64'(s_cyc - f_last_fs), 64'd160);
                  chk("active_pixels", 64'(f_act_cnt), 64'd48);
                  chk("vsync_low_pixels", 64'(f_vs_lo_cnt), 64'd32);
               end
               fc_frames++;
               f_last_fs   = s_cyc;
               f_act_cnt   = 0;
               f_vs_lo_cnt = 0;
            end
            f_act_cnt   += int'(f_act);
            f_vs_lo_cnt += int'(!f_vs);
         end
         if (s_cyc <= 40) chk("div2_tick", 64'(d2_pt), 64'(s_cyc % 2 == 0));
         if (d2_ls) chk("div2_pulse_needs_tick", 64'(d2_pt), 64'd1);
         if (d2_fs && d2_frames < 2) begin
            if (d2_frames == 0) chk("div2_first_fs", 64'(s_cyc), 64'd2);
            else                chk("div2_period", 64'(s_cyc - d2_last), 64'd320);
            d2_frames++;
            d2_last = s_cyc;
         end
         if (p_ls) begin
            if (p_lines > 0 && p_lines <= 20) chk("pol_hsync_pixels", 64'(p_hs_cnt), 64'd3);
            p_lines++;
            p_hs_cnt = 0;
         end
         p_hs_cnt += int'(p_hs);
         if (p_fs) begin
            if (p_frames > 0 && p_frames < 3) chk("pol_vsync_pixels", 64'(p_vs_cnt), 64'd32);
            p_frames++;
            p_vs_cnt = 0;
         end
         p_vs_cnt += int'(p_vs);
      end
   end

   // ---------------- vector table for the default instance ----------------
   typedef struct {
      string name;
      int    adv;
      int    col, row;
      bit    hs, vs, act, ls, fs;
      int    fc;
   } vec_t;

   function automatic vec_t mk(string n, int a, int c, int r, bit hs, bit vs,
                               bit act, bit ls, bit fs, int fc);
      vec_t v;
      v.name = n; v.adv = a; v.col = c; v.row = r;
      v.hs = hs; v.vs = vs; v.act = act; v.ls = ls; v.fs = fs; v.fc = fc;
      return v;
   endfunction

   function automatic logic [63:0] pack_vec(vec_t v);
      return 64'({10'(v.col), 10'(v.row), v.hs, v.vs, v.act, v.ls, v.fs, 8'(v.fc)});
   endfunction

   function automatic logic [63:0] pack_def();
      return 64'({d_col, d_row, d_hs, d_vs, d_act, d_ls, d_fs, d_fc});
   endfunction

   vec_t vt [9];

   initial begin
      int n;
      vt[0] = mk("first_tick",  1,   0, 0, 1, 1, 1, 1, 1, 1);
      vt[1] = mk("second_px",   1,   1, 0, 1, 1, 1, 0, 0, 1);
      vt[2] = mk("last_active", 638, 639, 0, 1, 1, 1, 0, 0, 1);
      vt[3] = mk("first_blank", 1,   640, 0, 1, 1, 0, 0, 0, 1);
      vt[4] = mk("hsync_first", 16,  656, 0, 0, 1, 0, 0, 0, 1);
      vt[5] = mk("hsync_last",  95,  751, 0, 0, 1, 0, 0, 0, 1);
      vt[6] = mk("hsync_end",   1,   752, 0, 1, 1, 0, 0, 0, 1);
      vt[7] = mk("line_end",    47,  799, 0, 1, 1, 0, 0, 0, 1);
      vt[8] = mk("line_two",    1,   0, 1, 1, 1, 1, 1, 0, 1);

      // reset state of every instance
      repeat (3) @(posedge clk);
      #1;
      chk("reset_default", pack_def(), pack_vec(mk("rst", 0, 799, 524, 1, 1, 0, 0, 0, 0)));
      chk("reset_default_tick", 64'(d_pt), 64'd0);
      chk("reset_fc2",  64'({f_col, f_row, f_hs, f_vs, f_act, f_pt, f_ls, f_fs, f_fc}),
                        64'({4'd15, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}));
      chk("reset_div2", 64'({d2_col, d2_row, d2_hs, d2_vs, d2_act, d2_pt, d2_ls, d2_fs, d2_fc}),
                        64'({4'd15, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}));
      chk("reset_pol",  64'({p_col, p_row, p_hs, p_vs, p_act, p_pt, p_ls, p_fs, p_fc}),
                        64'({4'd15, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}));

      @(negedge clk);
      rst_def = 1'b1;
      rst_s   = 1'b1;
      s_en    = 1'b1;

      foreach (vt[i]) begin
         repeat (vt[i].adv) @(posedge clk);
         #1;
         chk(vt[i].name, pack_def(), pack_vec(vt[i]));
      end

      // freeze at column 700 inside the horizontal sync
      n = 0;
      while (d_col != 10'd700 && n < 1000) begin
         @(posedge clk); #1; n++;
      end
      chk("reach_col700", 64'(d_col), 64'd700);
      run_def = 1'b0;
      repeat (50) begin
         @(posedge clk); #1;
         chk("run_hold", 64'({d_col, d_hs, d_fc, d_pt, d_ls, d_fs}),
                         64'({10'd700, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0}));
      end
      run_def = 1'b1;
      @(posedge clk); #1;
      chk("run_resume", 64'({d_col, d_pt}), 64'({10'd701, 1'b1}));

      // reset in the middle of a frame
      n = 0;
      while (!(d_row == 10'd2 && d_col == 10'd100) && n < 3000) begin
         @(posedge clk); #1; n++;
      end
      chk("reach_row2", 64'({d_row, d_col}), 64'({10'd2, 10'd100}));
      #2;
      rst_def = 1'b0;
      #1;
      chk("midframe_reset", 64'({d_col, d_row, d_act, d_fc, d_pt, d_ls, d_fs}),
                            64'({10'd799, 10'd524, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0}));
      @(negedge clk);
      rst_def = 1'b1;
      @(posedge clk); #1;
      chk("restart_tick", pack_def(), pack_vec(mk("rs", 0, 0, 0, 1, 1, 1, 1, 1, 1)));

      n = 0;
      while (!(fc_frames >= 5 && d2_frames >= 2 && p_frames >= 3) && n < 5000) begin
         @(posedge clk); n++;
      end
      chk("fc_frames_seen",  64'(fc_frames), 64'd5);
      chk("div2_frames_seen", 64'(d2_frames), 64'd2);
      chk("pol_frames_seen", 64'(p_frames >= 3), 64'd1);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
